// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: function codes,
// FSM state encoding and flag bit positions.
package alu_defs;

  localparam logic [5:0] FUNC_NOP = 6'b000000;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_MUL = 6'b011000;
  localparam logic [5:0] FUNC_DIV = 6'b011010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_NOT = 6'b100111;

  localparam int FLG_ABOVE  = 0;
  localparam int FLG_EQUALS = 1;
  localparam int FLG_OVF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic func_legal(
    input logic [5:0] f
  );
    logic ok;
    ok = 1'b0;
    case (f)
      FUNC_ADD, FUNC_SUB,
      FUNC_MUL, FUNC_DIV,
      FUNC_AND, FUNC_OR,
      FUNC_NOT: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request and writeback handshakes of the ALU issue controller.
// master = decode/writeback side, slave = the controller.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_func;
  logic [DATA_W-1:0] req_op1;
  logic [DATA_W-1:0] req_op2;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        wb_flags;
  logic              wb_trap;
  logic              wb_illegal;

  modport master (
    output req_valid,
    output req_func,
    output req_op1,
    output req_op2,
    input  req_ready,
    input  wb_valid,
    input  wb_data,
    input  wb_flags,
    input  wb_trap,
    input  wb_illegal,
    output wb_ready
  );

  modport slave (
    input  req_valid,
    input  req_func,
    input  req_op1,
    input  req_op2,
    output req_ready,
    output wb_valid,
    output wb_data,
    output wb_flags,
    output wb_trap,
    output wb_illegal,
    input  wb_ready
  );

endinterface

// File: rtl/alu_issue_ctrl_flag_gen.sv
// Regenerates {overflow, equals, above} from the operands and the
// low result bits, since the ALU's own flag bits are sticky.
module alu_flag_gen
  import alu_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);

  localparam int PW = 2 * DATA_W;

  logic          s1;
  logic          s2;
  logic          sr;
  logic [PW-1:0] prod;
  logic [DATA_W:0] prod_hi;

  assign s1 = op1[DATA_W-1];
  assign s2 = op2[DATA_W-1];
  assign sr = result[DATA_W-1];

  // Product fits iff the top DATA_W+1 bits are all sign copies.
  assign prod    = $signed(op1) * $signed(op2);
  assign prod_hi = prod[PW-1:DATA_W-1];

  always_comb begin
    flags = '0;
    unique case (1'b1)
      (func == FUNC_ADD): begin
        flags[FLG_OVF] = (s1 == s2) && (sr != s1);
      end
      (func == FUNC_SUB): begin
        flags[FLG_OVF]    = (s1 != s2) && (sr != s1);
        flags[FLG_EQUALS] = (result == '0);
        flags[FLG_ABOVE]  = !sr && (result != '0);
      end
      (func == FUNC_MUL): begin
        flags[FLG_OVF] = !((&prod_hi) || !(|prod_hi));
      end
      default: begin
        flags = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequences one request onto the func-triggered combinational ALU
// and returns a single writeback beat with locally derived flags.
module alu_issue_ctrl
  import alu_defs::*;
#(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [5:0]        alu_func,
  input  logic [34:0]       alu_result,
  output logic [2:0]        status_flags
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [5:0]        func_q;
  logic [2:0]        flags;
  logic [DATA_W-1:0] res;
  logic              is_legal;
  logic              is_div0;
  logic              last;
  logic              unused_hi;

  // Upper ALU bits never clear, so they carry no information.
  assign res       = alu_result[DATA_W-1:0];
  assign unused_hi = ^alu_result[34:DATA_W];

  assign is_legal = func_legal(bus.req_func);
  assign is_div0  = (bus.req_func == FUNC_DIV)
                 && (bus.req_op2 == '0);
  assign last     = (cnt_q == LAST);

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.wb_valid  = (state_q == ST_RESP);

  alu_flag_gen #(
    .DATA_W (DATA_W)
  ) u_flag_gen (
    .func   (func_q),
    .op1    (alu_op1),
    .op2    (alu_op2),
    .result (res),
    .flags  (flags)
  );

  always_comb begin
    state_d  = state_q;
    alu_func = FUNC_NOP;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (!is_legal || is_div0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_func = func_q;
        if (last) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      func_q         <= FUNC_NOP;
      alu_op1        <= '0;
      alu_op2        <= '0;
      bus.wb_data    <= '0;
      bus.wb_flags   <= '0;
      bus.wb_trap    <= 1'b0;
      bus.wb_illegal <= 1'b0;
      status_flags   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            func_q <= bus.req_func;
            cnt_q  <= '0;
            if (!is_legal) begin
              bus.wb_data    <= '0;
              bus.wb_flags   <= '0;
              bus.wb_trap    <= 1'b0;
              bus.wb_illegal <= 1'b1;
            end else if (is_div0) begin
              // Resolved here; the ALU is never triggered.
              bus.wb_data    <= '0;
              bus.wb_flags   <= 3'b100;
              bus.wb_trap    <= 1'b1;
              bus.wb_illegal <= 1'b0;
            end else begin
              alu_op1 <= bus.req_op1;
              alu_op2 <= bus.req_op2;
            end
          end
        end
        ST_EXEC: begin
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            bus.wb_data    <= res;
            bus.wb_flags   <= flags;
            bus.wb_trap    <= flags[FLG_OVF];
            bus.wb_illegal <= 1'b0;
          end
        end
        ST_RESP: begin
          if (bus.wb_ready) begin
            status_flags <= bus.wb_flags;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a timestamp-based reference
// model, a sticky-bit ALU stand-in and hand-computed literal checks.
module tb_alu_issue_ctrl;

  localparam int S = 1;
  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] MUL = 6'b011000;
  localparam logic [5:0] DIV = 6'b011010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] ORR = 6'b100101;
  localparam logic [5:0] NOT = 6'b100111;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    logic        trap;
    logic        illegal;
    logic        drives;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [5:0]  alu_func;
  logic [34:0] alu_result = '0;
  logic [2:0]  status_flags;

  int checks = 0;
  int failures = 0;

  alu_issue_ctrl_if #(.DATA_W(32)) bus ();

  alu_issue_ctrl #(
    .DATA_W     (32),
    .SETTLE_CYC (S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_func     (alu_func),
    .alu_result   (alu_result),
    .status_flags (status_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ALU stand-in: recomputes only when func changes, and its top bits stick.
  function automatic logic [31:0] alu_fn(input logic [5:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEADBEEF;
    case (f)
      ADD: r = a + b;
      SUB: r = a - b;
      MUL: r = 32'($signed(a) * $signed(b));
      DIV: r = (b == 0) ? 32'hBAD0BAD0 : 32'($signed(a) / $signed(b));
      AND: r = a & b;
      ORR: r = a | b;
      NOT: r = ~a;
      default: r = 32'hDEADBEEF;
    endcase
    return r;
  endfunction

  always @(alu_func) begin
    if (alu_func != NOP) begin
      alu_result[31:0]  = alu_fn(alu_func, alu_op1, alu_op2);
      alu_result[34:32] = 3'b111;
    end
  end

  function automatic beat_t model(input logic [5:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    beat_t r;
    longint sa;
    longint sb;
    longint full;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    full = 0;
    ovf = 1'b0;
    r.data = '0;
    r.flags = '0;
    r.trap = 1'b0;
    r.illegal = 1'b0;
    r.drives = 1'b1;
    r.func = f;
    r.a = a;
    r.b = b;
    r.k = S + 1;
    case (f)
      ADD, SUB, MUL: begin
        if (f == ADD) full = sa + sb;
        else if (f == SUB) full = sa - sb;
        else full = sa * sb;
        r.data = full[31:0];
        ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        r.flags[2] = ovf;
        if (f == SUB) begin
          r.flags[1] = (r.data == 0);
          r.flags[0] = ($signed(r.data) > 0);
        end
      end
      DIV: begin
        if (b == 0) begin
          r.flags = 3'b100;
          r.drives = 1'b0;
          r.k = 0;
        end else begin
          full = sa / sb;
          r.data = full[31:0];
        end
      end
      AND: r.data = a & b;
      ORR: r.data = a | b;
      NOT: r.data = ~a;
      default: begin
        r.illegal = 1'b1;
        r.drives = 1'b0;
        r.k = 0;
      end
    endcase
    r.trap = r.flags[2];
    return r;
  endfunction

  int    cyc = 0;
  int    m_acc = 0;
  int    m_off = 0;
  logic  m_busy = 1'b0;
  logic  m_valid = 1'b0;
  logic [2:0] m_status = '0;
  beat_t m_beat;

  initial begin
    m_beat = model(NOP, 0, 0);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy = 1'b0;
        m_status = '0;
      end else if (m_busy) begin
        if (m_valid && bus.wb_ready) begin
          m_busy = 1'b0;
          m_status = m_beat.flags;
        end
      end else if (bus.req_valid) begin
        m_beat = model(bus.req_func, bus.req_op1, bus.req_op2);
        m_busy = 1'b1;
        m_acc = cyc;
      end
      m_off = cyc - m_acc;
      m_valid = m_busy && (m_off >= m_beat.k);
    end
  end

  initial begin
    logic [5:0] ef;
    forever begin
      @(posedge clk);
      #1;
      chk("valid", 64'(bus.wb_valid), 64'(m_valid));
      chk("ready", 64'(bus.req_ready), 64'(!m_busy));
      ef = (m_busy && m_beat.drives && m_off >= 1 && m_off <= S)
           ? m_beat.func : NOP;
      chk("alu_func", 64'(alu_func), 64'(ef));
      chk("status", 64'(status_flags), 64'(m_status));
      if (m_busy && m_beat.drives && m_off <= S) begin
        chk("alu_op1", 64'(alu_op1), 64'(m_beat.a));
        chk("alu_op2", 64'(alu_op2), 64'(m_beat.b));
      end
      if (m_valid) begin
        chk("wb_data", 64'(bus.wb_data), 64'(m_beat.data));
        chk("wb_flags", 64'(bus.wb_flags), 64'(m_beat.flags));
        chk("wb_trap", 64'(bus.wb_trap), 64'(m_beat.trap));
        chk("wb_illegal", 64'(bus.wb_illegal), 64'(m_beat.illegal));
      end
    end
  end

  logic [31:0] g_data;
  logic [2:0]  g_flags;
  logic        g_trap;
  logic        g_ill;
  int          g_k;

  task automatic send(input logic [5:0] f,
                      input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_func = f;
    bus.req_op1 = a;
    bus.req_op2 = b;
    for (int n = 0; n < 50; n++) begin
      if (bus.req_ready) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic get_beat(input int hold);
    g_k = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.wb_valid) begin
        g_k = i;
        break;
      end
      @(negedge clk);
    end
    if (g_k < 0) begin
      chk("beat_timeout", 64'd1, 64'd0);
      return;
    end
    g_data = bus.wb_data;
    g_flags = bus.wb_flags;
    g_trap = bus.wb_trap;
    g_ill = bus.wb_illegal;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.wb_valid), 64'd1);
      chk("hold_data", 64'(bus.wb_data), 64'(g_data));
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_func = NOP;
    bus.req_op1 = '0;
    bus.req_op2 = '0;
    bus.wb_ready = 1'b0;
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_func", 64'(alu_func), 64'(NOP));
    chk("rst_data", 64'(bus.wb_data), 64'd0);
    chk("rst_op1", 64'(alu_op1), 64'd0);
    chk("rst_status", 64'(status_flags), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(ADD, 32'h7FFFFFFF, 32'h1);
    get_beat(0);
    chk("t1_lat", 64'(g_k), 64'd2);
    chk("t1_data", 64'(g_data), 64'h80000000);
    chk("t1_flags", 64'(g_flags), 64'b100);
    chk("t1_trap", 64'(g_trap), 64'd1);

    send(SUB, 32'd5, 32'd5);
    get_beat(0);
    chk("t2a_data", 64'(g_data), 64'd0);
    chk("t2a_flags", 64'(g_flags), 64'b010);
    send(SUB, 32'd9, 32'd3);
    get_beat(0);
    chk("t2b_data", 64'(g_data), 64'd6);
    chk("t2b_flags", 64'(g_flags), 64'b001);

    send(DIV, 32'd10, 32'd0);
    chk("t3_func", 64'(alu_func), 64'(NOP));
    get_beat(0);
    chk("t3_lat", 64'(g_k), 64'd0);
    chk("t3_data", 64'(g_data), 64'd0);
    chk("t3_flags", 64'(g_flags), 64'b100);
    chk("t3_trap", 64'(g_trap), 64'd1);

    send(MUL, 32'h00010000, 32'h00010000);
    get_beat(0);
    chk("t4a_data", 64'(g_data), 64'd0);
    chk("t4a_ovf", 64'(g_flags[2]), 64'd1);
    send(MUL, 32'd3, 32'hFFFFFFFC);
    get_beat(0);
    chk("t4b_data", 64'(g_data), 64'hFFFFFFF4);
    chk("t4b_flags", 64'(g_flags), 64'b000);

    send(DIV, 32'hFFFFFFF7, 32'd2);
    get_beat(0);
    chk("div_data", 64'(g_data), 64'hFFFFFFFC);
    send(AND, 32'hF0F0F0F0, 32'hFF00FF00);
    get_beat(0);
    chk("and_data", 64'(g_data), 64'hF000F000);
    send(NOT, 32'h0000FFFF, 32'd0);
    get_beat(0);
    chk("not_data", 64'(g_data), 64'hFFFF0000);

    send(6'b111111, 32'd1, 32'd2);
    get_beat(5);
    chk("t5_ill", 64'(g_ill), 64'd1);
    chk("t5_data", 64'(g_data), 64'd0);
    chk("t5_flags", 64'(g_flags), 64'd0);

    send(ADD, 32'd1, 32'd1);
    @(negedge clk);
    chk("t6_exec", 64'(alu_func), 64'(ADD));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(bus.wb_valid), 64'd0);
    chk("t6_ready", 64'(bus.req_ready), 64'd1);
    chk("t6_func", 64'(alu_func), 64'(NOP));
    chk("t6_op1", 64'(alu_op1), 64'd0);
    chk("t6_status", 64'(status_flags), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_nobeat", 64'(bus.wb_valid), 64'd0);
    end
    send(ADD, 32'd2, 32'd3);
    get_beat(0);
    chk("t6_data", 64'(g_data), 64'd5);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
